// File: rtl/async_oneway_receiver.sv
// Purpose : receive end of the one-way 6-bit packet link; resyncs ctrl/pulse, rebuilds datagrams.
// Latency : ctrl/pulse edges seen SYNC_STAGES+1 clk_recv after they arrive; datagram 1 cycle after last capture.
// Backpr. : none -- the link is one-way, so stray or overrun packets are flagged on frame_error and dropped.
//
// Ports:
//   clk_recv       receive-domain clock (only clock in this block)
//   rst_n          asynchronous active-low reset
//   packet_in      6-bit packet data, held stable by the transmitter around each strobe
//   transmit_ctrl  frame-active level from the foreign domain
//   packet_pulse   packet strobe from the foreign domain (one clk_send wide)
//   datagram_out   last completed datagram, held until the next completion
//   datagram_valid 1-cycle strobe when datagram_out updates
//   frame_error    1-cycle strobe on truncated frame, stray packet or overrun
//   busy           high while a frame is in progress
module async_oneway_receiver #(
    parameter int MESSAGE_SIZE = 48,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk_recv,
    input  logic                    rst_n,
    input  logic [5:0]              packet_in,
    input  logic                    transmit_ctrl,
    input  logic                    packet_pulse,
    output logic [MESSAGE_SIZE-1:0] datagram_out,
    output logic                    datagram_valid,
    output logic                    frame_error,
    output logic                    busy
);

    localparam int NPKT  = (MESSAGE_SIZE + 5) / 6;
    localparam int BUF_W = NPKT * 6;
    localparam int CNT_W = $clog2(NPKT + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RECV     = 2'd1,
        S_WAIT_END = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  ctrl_sync_q, pulse_sync_q;
    logic                    ctrl_prev_q, pulse_prev_q;
    logic [BUF_W-1:0]        buf_q, buf_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    complete_q, complete_d;
    logic [MESSAGE_SIZE-1:0] dout_q, dout_d;
    logic                    valid_q, valid_d;
    logic                    ferr_q, ferr_d;

    logic                    ctrl_s, pulse_s;
    logic                    ctrl_rise, ctrl_fall, pulse_rise;
    logic                    cap, last_cap, err;
    logic [CNT_W-1:0]        cnt_base, cnt_inc;

    // Edge detection on the last synchronizer flop against a one-cycle-delayed copy.
    assign ctrl_s     = ctrl_sync_q[SYNC_STAGES-1];
    assign pulse_s    = pulse_sync_q[SYNC_STAGES-1];
    assign ctrl_rise  = ctrl_s & ~ctrl_prev_q;
    assign ctrl_fall  = ~ctrl_s & ctrl_prev_q;
    assign pulse_rise = pulse_s & ~pulse_prev_q;

    // A capture is legal while receiving, or in idle when the frame opens in the same cycle.
    // packet_in is not synchronized: it has been stable for longer than the pulse sync delay.
    assign cap      = pulse_rise & (((state_q == S_IDLE) & ctrl_rise) | (state_q == S_RECV));
    assign cnt_base = (state_q == S_IDLE) ? '0 : cnt_q;
    assign cnt_inc  = cnt_base + CNT_W'(1);
    assign last_cap = cap & (cnt_inc == CNT_W'(NPKT));

    // State register and all other sequential state.
    always_ff @(posedge clk_recv or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ctrl_sync_q  <= '0;
            pulse_sync_q <= '0;
            ctrl_prev_q  <= 1'b0;
            pulse_prev_q <= 1'b0;
            buf_q        <= '0;
            cnt_q        <= '0;
            complete_q   <= 1'b0;
            dout_q       <= '0;
            valid_q      <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctrl_sync_q  <= {ctrl_sync_q[SYNC_STAGES-2:0], transmit_ctrl};
            pulse_sync_q <= {pulse_sync_q[SYNC_STAGES-2:0], packet_pulse};
            ctrl_prev_q  <= ctrl_s;
            pulse_prev_q <= pulse_s;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            complete_q   <= complete_d;
            dout_q       <= dout_d;
            valid_q      <= valid_d;
            ferr_q       <= ferr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ctrl_rise) begin
                    state_d = last_cap ? S_WAIT_END : S_RECV;
                end
            end
            S_RECV: begin
                // A fall coinciding with the final capture is a clean end of frame.
                if (last_cap) begin
                    state_d = ctrl_fall ? S_IDLE : S_WAIT_END;
                end else if (ctrl_fall) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_END: begin
                if (ctrl_fall) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        err = 1'b0;
        case (state_q)
            S_IDLE:     err = ~ctrl_rise & pulse_rise & ~ctrl_s;
            S_RECV:     err = ctrl_fall & ~last_cap;
            S_WAIT_END: err = pulse_rise;
            default:    err = 1'b0;
        endcase

        buf_d = buf_q;
        cnt_d = cnt_q;
        if (cap) begin
            buf_d = {packet_in, buf_q[BUF_W-1:6]};
            cnt_d = cnt_inc;
        end else if ((state_q == S_IDLE) && ctrl_rise) begin
            cnt_d = '0;
        end

        complete_d = last_cap;
        dout_d     = complete_q ? buf_q[MESSAGE_SIZE-1:0] : dout_q;
        valid_d    = complete_q;
        // Delivery wins if an error lands on the delivery cycle, so the strobes stay exclusive.
        ferr_d     = err & ~complete_q;
    end

    assign datagram_out   = dout_q;
    assign datagram_valid = valid_q;
    assign frame_error    = ferr_q;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_async_oneway_receiver.sv
// Purpose : directed bench for async_oneway_receiver (48-bit and 20-bit instances).
// Latency : transmitter modelled at clk_recv/4; every wait is a fixed cycle count.
// Backpr. : none; strobes are counted by a negedge monitor and compared as deltas.
module tb_async_oneway_receiver;

    logic        clk_recv = 1'b0;
    logic        rst_n    = 1'b0;
    logic [5:0]  packet_in = '0;
    logic        packet_pulse = 1'b0;
    logic        ctrl48 = 1'b0;
    logic        ctrl20 = 1'b0;

    logic [47:0] dout48;
    logic        valid48, ferr48, busy48;
    logic [19:0] dout20;
    logic        valid20, ferr20, busy20;

    int passed = 0;
    int total  = 0;
    int vc48 = 0, ec48 = 0, vc20 = 0, ec20 = 0;
    int v0, e0;

    always #5 clk_recv = ~clk_recv;

    async_oneway_receiver #(.MESSAGE_SIZE(48), .SYNC_STAGES(2)) dut48 (
        .clk_recv       (clk_recv),
        .rst_n          (rst_n),
        .packet_in      (packet_in),
        .transmit_ctrl  (ctrl48),
        .packet_pulse   (packet_pulse),
        .datagram_out   (dout48),
        .datagram_valid (valid48),
        .frame_error    (ferr48),
        .busy           (busy48)
    );

    async_oneway_receiver #(.MESSAGE_SIZE(20), .SYNC_STAGES(2)) dut20 (
        .clk_recv       (clk_recv),
        .rst_n          (rst_n),
        .packet_in      (packet_in),
        .transmit_ctrl  (ctrl20),
        .packet_pulse   (packet_pulse),
        .datagram_out   (dout20),
        .datagram_valid (valid20),
        .frame_error    (ferr20),
        .busy           (busy20)
    );

    // Strobe counters, sampled away from the active edge.
    always @(negedge clk_recv) begin
        if (valid48) vc48++;
        if (ferr48)  ec48++;
        if (valid20) vc20++;
        if (ferr20)  ec20++;
    end

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_recv);
    endtask

    // One packet at clk_send = clk_recv/4: pulse high one clk_send period, data held two.
    task automatic send_pkt(input logic [5:0] p);
        packet_in    = p;
        packet_pulse = 1'b1;
        cycles(4);
        packet_pulse = 1'b0;
        cycles(4);
    endtask

    // Frame of n packets, LSB packet first; ctrl dropped at the end unless keep is set.
    task automatic send_frame(input logic [59:0] data, input int n, input bit to20, input bit keep);
        @(negedge clk_recv);
        if (to20) ctrl20 = 1'b1; else ctrl48 = 1'b1;
        cycles(4);
        for (int i = 0; i < n; i++) send_pkt(data[i*6 +: 6]);
        if (!keep) begin
            if (to20) ctrl20 = 1'b0; else ctrl48 = 1'b0;
            cycles(1);
        end
    endtask

    initial begin
        // T1: reset held with toggling inputs
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_recv);
            ctrl48 = ~ctrl48;
            ctrl20 = ~ctrl20;
            packet_pulse = ~packet_pulse;
            packet_in = 6'(i * 11);
        end
        check("rst_dout48", dout48, 48'h0);
        check("rst_flags48", {45'h0, valid48, ferr48, busy48}, 48'h0);
        check("rst_dout20", {28'h0, dout20}, 48'h0);
        ctrl48 = 1'b0; ctrl20 = 1'b0; packet_pulse = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(6);
        check("post_rst_flags48", {45'h0, valid48, ferr48, busy48}, 48'h0);
        check("post_rst_busy20", {47'h0, busy20}, 48'h0);

        // T2: two back-to-back 48-bit frames
        v0 = vc48; e0 = ec48;
        send_frame({12'h0, 48'h0123_4567_89AB}, 8, 1'b0, 1'b0);
        check("t2a_dout", dout48, 48'h0123_4567_89AB);
        check("t2a_valid_cnt", 48'(vc48 - v0), 48'd1);
        check("t2a_err_cnt", 48'(ec48 - e0), 48'd0);
        v0 = vc48;
        send_frame({12'h0, 48'hFFFF_0000_A5A5}, 8, 1'b0, 1'b0);
        cycles(4);
        check("t2b_dout", dout48, 48'hFFFF_0000_A5A5);
        check("t2b_valid_cnt", 48'(vc48 - v0), 48'd1);
        check("t2b_err_cnt", 48'(ec48 - e0), 48'd0);
        check("t2b_busy", {47'h0, busy48}, 48'h0);

        // T3: 20-bit datagram, padding bits of the last packet set
        v0 = vc20; e0 = ec20;
        send_frame({36'h0, 24'hFABCDE}, 4, 1'b1, 1'b0);
        cycles(4);
        check("t3_dout20", {28'h0, dout20}, {28'h0, 20'hABCDE});
        check("t3_valid_cnt", 48'(vc20 - v0), 48'd1);
        check("t3_err_cnt", 48'(ec20 - e0), 48'd0);

        // T4: truncated frame
        v0 = vc48; e0 = ec48;
        send_frame({12'h0, 48'h0000_0000_0FFF}, 3, 1'b0, 1'b0);
        cycles(6);
        check("t4_err_cnt", 48'(ec48 - e0), 48'd1);
        check("t4_valid_cnt", 48'(vc48 - v0), 48'd0);
        check("t4_dout_kept", dout48, 48'hFFFF_0000_A5A5);
        check("t4_busy", {47'h0, busy48}, 48'h0);

        // T5a: stray pulse with ctrl low
        e0 = ec48;
        cycles(1);
        send_pkt(6'h2A);
        cycles(2);
        check("t5_stray_err", 48'(ec48 - e0), 48'd1);
        check("t5_stray_busy", {47'h0, busy48}, 48'h0);

        // T5b: overrun, ninth packet while waiting for ctrl to drop
        v0 = vc48; e0 = ec48;
        send_frame({12'h3F0, 48'h1122_3344_5566}, 9, 1'b0, 1'b0);
        cycles(4);
        check("t5_ovr_dout", dout48, 48'h1122_3344_5566);
        check("t5_ovr_valid", 48'(vc48 - v0), 48'd1);
        check("t5_ovr_err", 48'(ec48 - e0), 48'd1);

        // T6: reset after 4 of 8 packets, then a full frame
        send_frame({12'h0, 48'h0BAD_0BAD_0BAD}, 4, 1'b0, 1'b1);
        check("t6_busy_mid", {47'h0, busy48}, 48'h1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_dout", dout48, 48'h0);
        check("t6_rst_flags", {45'h0, valid48, ferr48, busy48}, 48'h0);
        ctrl48 = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(4);
        v0 = vc48; e0 = ec48;
        send_frame({12'h0, 48'hDEAD_BEEF_0042}, 8, 1'b0, 1'b0);
        cycles(4);
        check("t6_dout", dout48, 48'hDEAD_BEEF_0042);
        check("t6_valid_cnt", 48'(vc48 - v0), 48'd1);
        check("t6_err_cnt", 48'(ec48 - e0), 48'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
